// File: rtl/single_port_ram_bist_pkg.sv
// Shared types and command-word helpers for the single-port RAM march BIST.
// Helpers work on a wide scratch width; callers cast down to DATA_W.
package single_port_ram_bist_pkg;

  localparam int unsigned CmdMaxW   = 64;
  localparam int unsigned DrainCntW = 3;

  typedef enum logic [2:0] {
    StIdle,
    StWr0,
    StRd0,
    StWr1,
    StRd1,
    StDone
  } bist_state_e;

  // Phase 0 payload is the seed's upper bits XOR the address; phase 1 is its inverse.
  function automatic logic [CmdMaxW-1:0] payload(input logic               phase,
                                                 input logic [CmdMaxW-1:0] addr,
                                                 input logic [CmdMaxW-1:0] seed,
                                                 input int unsigned        addr_w);
    logic [CmdMaxW-1:0] p;
    p = (seed >> (addr_w + 1)) ^ addr;
    return phase ? ~p : p;
  endfunction

  function automatic logic [CmdMaxW-1:0] pack_cmd(input logic [CmdMaxW-1:0] payload_w,
                                                  input logic [CmdMaxW-1:0] addr,
                                                  input logic               we,
                                                  input int unsigned        addr_w);
    return (payload_w << (addr_w + 1)) | (addr << 1) | CmdMaxW'(we);
  endfunction

endpackage

// File: rtl/single_port_ram_bist_if.sv
// Packed command / read-data link between the BIST and the RAM top.
interface single_port_ram_bist_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic [DATA_W-1:0] cmd_word;
  logic [DATA_W-1:0] rd_data;

  modport master (output cmd_word, input rd_data);
  modport slave  (input cmd_word, output rd_data);

endinterface

// File: rtl/bist_expect_pipe.sv
// Delay line of {valid, addr, expected word} aligning expectations with RAM read latency.
module bist_expect_pipe #(
  parameter int unsigned Depth = 2,
  parameter int unsigned AddrW = 6,
  parameter int unsigned DataW = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             shift_i,
  input  logic             in_valid_i,
  input  logic [AddrW-1:0] in_addr_i,
  input  logic [DataW-1:0] in_data_i,
  output logic             tail_valid_o,
  output logic [AddrW-1:0] tail_addr_o,
  output logic [DataW-1:0] tail_data_o
);

  logic [Depth-1:0] valid_q, valid_d;
  logic [AddrW-1:0] addr_q [Depth];
  logic [AddrW-1:0] addr_d [Depth];
  logic [DataW-1:0] data_q [Depth];
  logic [DataW-1:0] data_d [Depth];

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (shift_i) begin
      valid_d[0] = in_valid_i;
      addr_d[0]  = in_addr_i;
      data_d[0]  = in_data_i;
      for (int i = 1; i < Depth; i++) begin
        valid_d[i] = valid_q[i-1];
        addr_d[i]  = addr_q[i-1];
        data_d[i]  = data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      addr_q  <= '{default: '0};
      data_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign tail_valid_o = valid_q[Depth-1];
  assign tail_addr_o  = addr_q[Depth-1];
  assign tail_data_o  = data_q[Depth-1];

endmodule

// File: rtl/single_port_ram_bist.sv
// Four-phase march BIST (write P0, read P0, write ~P0, read ~P0) over a packed-command RAM.
module single_port_ram_bist
  import single_port_ram_bist_pkg::*;
#(
  parameter int unsigned       ADDR_W = 6,
  parameter int unsigned       DATA_W = 32,
  parameter int unsigned       RD_LAT = 2,
  parameter logic [DATA_W-1:0] SEED   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  single_port_ram_bist_if.master ram_if,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ADDR_W-1:0]      fail_addr,
  output logic [7:0]             err_count
);

  bist_state_e          state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W-1:0]    fail_q, fail_d;
  logic [7:0]           err_q, err_d;
  logic                 in_drain_q, in_drain_d;
  logic [DrainCntW-1:0] drain_cnt_q, drain_cnt_d;

  logic              phase1, last_addr, push_valid;
  logic [DATA_W-1:0] wr_word, rd_word, cmd;
  logic              tail_valid;
  logic [ADDR_W-1:0] tail_addr;
  logic [DATA_W-1:0] tail_data;

  assign phase1    = (state_q == StWr1) || (state_q == StRd1);
  assign last_addr = (addr_q == '1);

  // The write word doubles as the expected read-back value.
  assign wr_word = DATA_W'(pack_cmd(payload(phase1, CmdMaxW'(addr_q), CmdMaxW'(SEED), ADDR_W),
                                    CmdMaxW'(addr_q), 1'b1, ADDR_W));
  assign rd_word = DATA_W'(pack_cmd('0, CmdMaxW'(addr_q), 1'b0, ADDR_W));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    fail_d      = fail_q;
    err_d       = err_q;
    in_drain_d  = in_drain_q;
    drain_cnt_d = drain_cnt_q;
    cmd         = '0;
    push_valid  = 1'b0;

    if (tail_valid && (ram_if.rd_data != tail_data)) begin
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
      if (err_q == 8'd0)  fail_d = tail_addr;
    end

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StWr0;
          addr_d      = '0;
          err_d       = '0;
          fail_d      = '0;
          in_drain_d  = 1'b0;
          drain_cnt_d = '0;
        end
      end
      StWr0, StWr1: begin
        cmd    = wr_word;
        addr_d = addr_q + ADDR_W'(1);
        if (last_addr) state_d = (state_q == StWr0) ? StRd0 : StRd1;
      end
      StRd0, StRd1: begin
        if (!in_drain_q) begin
          cmd        = rd_word;
          push_valid = 1'b1;
          addr_d     = addr_q + ADDR_W'(1);
          if (last_addr) begin
            in_drain_d  = 1'b1;
            drain_cnt_d = '0;
          end
        end else if (drain_cnt_q == DrainCntW'(RD_LAT - 1)) begin
          // Last in-flight read is compared in this cycle.
          in_drain_d = 1'b0;
          state_d    = (state_q == StRd0) ? StWr1 : StDone;
        end else begin
          drain_cnt_d = drain_cnt_q + DrainCntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      fail_q      <= '0;
      err_q       <= '0;
      in_drain_q  <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      fail_q      <= fail_d;
      err_q       <= err_d;
      in_drain_q  <= in_drain_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  bist_expect_pipe #(
    .Depth (RD_LAT),
    .AddrW (ADDR_W),
    .DataW (DATA_W)
  ) u_expect_pipe (
    .clk_i        (clk),
    .rst_ni       (rst),
    .shift_i      (busy),
    .in_valid_i   (push_valid),
    .in_addr_i    (addr_q),
    .in_data_i    (wr_word),
    .tail_valid_o (tail_valid),
    .tail_addr_o  (tail_addr),
    .tail_data_o  (tail_data)
  );

  assign ram_if.cmd_word = cmd;
  assign busy            = (state_q != StIdle) && (state_q != StDone);
  assign done            = (state_q == StDone);
  assign pass            = done && (err_q == 8'd0);
  assign fail_addr       = fail_q;
  assign err_count       = err_q;

endmodule

// File: tb/tb_single_port_ram_bist.sv
// Bench: three BIST instances (RD_LAT 1/2/4) each beside a behavioural RAM with fault injection.
module tb_single_port_ram_bist;

  localparam int          N     = 64;
  localparam logic [31:0] SEED2 = 32'h5A5A_C3C3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start_v;
  logic [2:0]  busy_v, done_v, pass_v;
  logic [5:0]  fail_v [3];
  logic [7:0]  err_v [3];
  logic [31:0] cmd_mon [3];
  int          fmode [3];
  int          faddr [3];
  int          fbit [3];
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Lat  = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    localparam logic [31:0] Seed = (g == 2) ? SEED2 : 32'h0;

    single_port_ram_bist_if #(.DATA_W(32)) bus ();

    single_port_ram_bist #(
      .ADDR_W (6),
      .DATA_W (32),
      .RD_LAT (Lat),
      .SEED   (Seed)
    ) u_dut (
      .clk       (clk),
      .rst       (rst_n),
      .start     (start_v[g]),
      .ram_if    (bus),
      .busy      (busy_v[g]),
      .done      (done_v[g]),
      .pass      (pass_v[g]),
      .fail_addr (fail_v[g]),
      .err_count (err_v[g])
    );

    logic [31:0] mem [64];
    logic [31:0] rdp [Lat];
    logic [5:0]  ma;

    assign ma = bus.cmd_word[6:1];

    // RAM model: full word stored on write, optional stuck-at-0 cell, Lat-cycle read path.
    always @(posedge clk) begin
      if (bus.cmd_word[0])
        mem[ma] <= (fmode[g] == 1 && int'(ma) == faddr[g]) ?
                   (bus.cmd_word & ~(32'd1 << fbit[g])) : bus.cmd_word;
      rdp[0] <= mem[ma];
      for (int i = 1; i < Lat; i++) rdp[i] <= rdp[i-1];
    end

    assign bus.rd_data = (fmode[g] == 2) ? 32'd0 : rdp[Lat-1];
    assign cmd_mon[g]  = bus.cmd_word;
  end

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] seed_of(input int g);
    return (g == 2) ? SEED2 : 32'h0;
  endfunction

  function automatic logic [31:0] exp_word(input int k, input int a, input logic [31:0] seed);
    logic [24:0] p;
    logic [5:0]  a6;
    a6 = a[5:0];
    p  = seed[31:7] ^ {19'd0, a6};
    if (k != 0) p = ~p;
    return {p, a6, 1'b1};
  endfunction

  function automatic logic [31:0] rd_cmd(input int a);
    logic [31:0] w;
    w      = '0;
    w[6:1] = a[5:0];
    return w;
  endfunction

  // Expected command word c cycles after the first write-phase-0 cycle.
  function automatic logic [31:0] exp_cmd(input int c, input int lat, input logic [31:0] seed);
    if (c < N)             return exp_word(0, c, seed);
    if (c < 2*N)           return rd_cmd(c - N);
    if (c < 2*N + lat)     return 32'd0;
    if (c < 3*N + lat)     return exp_word(1, c - 2*N - lat, seed);
    if (c < 4*N + lat)     return rd_cmd(c - 3*N - lat);
    return 32'd0;
  endfunction

  task automatic model_result(input int mode, input int f_addr, input int f_bit,
                              input logic [31:0] seed, output int cnt, output int first);
    logic [31:0] want, got;
    cnt   = 0;
    first = 0;
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < N; a++) begin
        want = exp_word(k, a, seed);
        got  = want;
        if (mode == 1 && a == f_addr) got = got & ~(32'd1 << f_bit);
        if (mode == 2) got = 32'd0;
        if (got != want) begin
          if (cnt == 0) first = a;
          if (cnt < 255) cnt++;
        end
      end
    end
  endtask

  task automatic run_bist(input int g, input int mode, input int f_addr, input int f_bit,
                          input int gap, input int glitch_c, input int abort_c,
                          input string name, output logic [31:0] w0_5,
                          output logic [31:0] w1_5, output int run_len);
    int          lat, total, bad_cmd, bad_busy, first_c, m_err, m_fail;
    logic [31:0] seed, exp_c, bad_act, bad_exp;
    bit          aborted;
    lat      = lat_of(g);
    seed     = seed_of(g);
    total    = 4*N + 2*lat;
    fmode[g] = mode;
    faddr[g] = f_addr;
    fbit[g]  = f_bit;
    bad_cmd  = 0;
    bad_busy = 0;
    first_c  = -1;
    run_len  = -1;
    aborted  = 0;
    w0_5     = '0;
    w1_5     = '0;
    bad_act  = '0;
    bad_exp  = '0;
    repeat (gap) begin @(posedge clk); #1; end
    start_v[g] = 1'b1;
    @(posedge clk); #1;
    start_v[g] = 1'b0;
    checks++;
    if (err_v[g] !== 8'd0 || done_v[g] !== 1'b0 || fail_v[g] !== 6'd0)
      $display("FAIL %s clear_on_start: err=%0d done=%0b fail_addr=%0d, want 0/0/0",
               name, err_v[g], done_v[g], fail_v[g]);
    else passes++;
    for (int c = 0; c <= total + 8; c++) begin
      exp_c = exp_cmd(c, lat, seed);
      if (cmd_mon[g] !== exp_c) begin
        if (bad_cmd == 0) begin first_c = c; bad_act = cmd_mon[g]; bad_exp = exp_c; end
        bad_cmd++;
      end
      if (c == 5) w0_5 = cmd_mon[g];
      if (c == 2*N + lat + 5) w1_5 = cmd_mon[g];
      if (done_v[g] === 1'b1) begin run_len = c; break; end
      if (busy_v[g] !== 1'b1) bad_busy++;
      if (c == abort_c) begin
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cmd_mon[g] !== 32'd0 || busy_v[g] !== 1'b0 || done_v[g] !== 1'b0)
          $display("FAIL %s async_abort: cmd=%08h busy=%0b done=%0b, want 0/0/0",
                   name, cmd_mon[g], busy_v[g], done_v[g]);
        else passes++;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        aborted = 1;
        break;
      end
      if (c == glitch_c) start_v[g] = 1'b1;
      @(posedge clk); #1;
      start_v[g] = 1'b0;
    end
    checks++;
    if (bad_cmd != 0)
      $display("FAIL %s cmd_sequence: %0d bad cycles, first at c=%0d got %08h want %08h",
               name, bad_cmd, first_c, bad_act, bad_exp);
    else passes++;
    if (!aborted) begin
      model_result(mode, f_addr, f_bit, seed, m_err, m_fail);
      checks++;
      if (bad_busy != 0 || run_len != total)
        $display("FAIL %s run_length: done at c=%0d busy-low cycles=%0d, want c=%0d and 0",
                 name, run_len, bad_busy, total);
      else passes++;
      checks++;
      if (int'(err_v[g]) != m_err || int'(fail_v[g]) != m_fail || pass_v[g] !== (m_err == 0))
        $display("FAIL %s result: err=%0d fail_addr=%0d pass=%0b, want %0d/%0d/%0b",
                 name, err_v[g], fail_v[g], pass_v[g], m_err, m_fail, m_err == 0);
      else passes++;
      @(posedge clk); #1;
      checks++;
      if (done_v[g] !== 1'b1 || busy_v[g] !== 1'b0 || cmd_mon[g] !== 32'd0)
        $display("FAIL %s done_hold: done=%0b busy=%0b cmd=%08h, want 1/0/0",
                 name, done_v[g], busy_v[g], cmd_mon[g]);
      else passes++;
    end
  endtask

  task automatic test_reset();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({cmd_mon[g], busy_v[g], done_v[g], pass_v[g], fail_v[g], err_v[g]} !== '0)
        $display("FAIL reset_state[%0d]: cmd=%08h busy=%0b done=%0b pass=%0b fail=%0d err=%0d, want all 0",
                 g, cmd_mon[g], busy_v[g], done_v[g], pass_v[g], fail_v[g], err_v[g]);
      else passes++;
    end
  endtask

  task automatic test_ideal();
    logic [31:0] w0, w1;
    int          len;
    run_bist(1, 0, 0, 0, $urandom_range(0, 3), -1, -1, "ideal", w0, w1, len);
    checks++;
    if (w0 !== 32'h0000_028B) $display("FAIL wr0_addr5: got %08h want 0000028b", w0);
    else passes++;
    checks++;
    if (w1 !== 32'hFFFF_FD0B) $display("FAIL wr1_addr5: got %08h want fffffd0b", w1);
    else passes++;
    checks++;
    if (len != 260 || pass_v[1] !== 1'b1 || err_v[1] !== 8'd0)
      $display("FAIL ideal_summary: len=%0d pass=%0b err=%0d, want 260/1/0", len, pass_v[1], err_v[1]);
    else passes++;
  endtask

  task automatic test_stuck_bit();
    logic [31:0] w0, w1;
    int          len;
    run_bist(1, 1, 3, 10, $urandom_range(0, 3), -1, -1, "stuck_a3_b10", w0, w1, len);
    checks++;
    if (err_v[1] !== 8'd1 || fail_v[1] !== 6'd3 || pass_v[1] !== 1'b0)
      $display("FAIL stuck_a3_b10_const: err=%0d fail=%0d pass=%0b, want 1/3/0",
               err_v[1], fail_v[1], pass_v[1]);
    else passes++;
    for (int i = 0; i < 3; i++)
      run_bist(1, 1, $urandom_range(0, 63), $urandom_range(0, 31), $urandom_range(0, 3),
               -1, -1, "stuck_random", w0, w1, len);
  endtask

  task automatic test_all_zero();
    logic [31:0] w0, w1;
    int          len;
    run_bist(1, 2, 0, 0, $urandom_range(0, 3), -1, -1, "all_zero", w0, w1, len);
    checks++;
    if (err_v[1] !== 8'd128 || fail_v[1] !== 6'd0 || pass_v[1] !== 1'b0)
      $display("FAIL all_zero_const: err=%0d fail=%0d pass=%0b, want 128/0/0",
               err_v[1], fail_v[1], pass_v[1]);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w0, w1;
    int          len;
    // Entered straight from the failing all-zero run, so clear-on-start is observable.
    for (int r = 0; r < 2; r++) begin
      run_bist(1, 0, 0, 0, 0, -1, -1, "back_to_back", w0, w1, len);
      checks++;
      if (len != 260 || pass_v[1] !== 1'b1 || w0 !== 32'h0000_028B)
        $display("FAIL back_to_back_run%0d: len=%0d pass=%0b w0=%08h, want 260/1/0000028b",
                 r, len, pass_v[1], w0);
      else passes++;
    end
  endtask

  task automatic test_start_ignored_abort();
    logic [31:0] w0, w1;
    int          len;
    run_bist(1, 0, 0, 0, $urandom_range(0, 3), N + int'($urandom_range(0, N - 1)),
             2*N + 2 + int'($urandom_range(0, N - 1)), "glitch_abort", w0, w1, len);
    run_bist(1, 0, 0, 0, $urandom_range(0, 3), -1, -1, "after_abort", w0, w1, len);
    checks++;
    if (len != 260 || pass_v[1] !== 1'b1)
      $display("FAIL after_abort_clean: len=%0d pass=%0b, want 260/1", len, pass_v[1]);
    else passes++;
  endtask

  task automatic test_latency();
    logic [31:0] w0, w1;
    int          len;
    run_bist(0, 0, 0, 0, $urandom_range(0, 3), -1, -1, "lat1", w0, w1, len);
    checks++;
    if (len != 258 || pass_v[0] !== 1'b1)
      $display("FAIL lat1_len: len=%0d pass=%0b, want 258/1", len, pass_v[0]);
    else passes++;
    run_bist(2, 0, 0, 0, $urandom_range(0, 3), -1, -1, "lat4_seed", w0, w1, len);
    checks++;
    if (len != 264 || pass_v[2] !== 1'b1)
      $display("FAIL lat4_len: len=%0d pass=%0b, want 264/1", len, pass_v[2]);
    else passes++;
    run_bist(2, 1, $urandom_range(0, 63), $urandom_range(0, 31), 0, -1, -1, "lat4_stuck",
             w0, w1, len);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int g = 0; g < 3; g++) begin fmode[g] = 0; faddr[g] = 0; fbit[g] = 0; end
    start_v = '0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_ideal();
    test_stuck_bit();
    test_all_zero();
    test_back_to_back();
    test_start_ignored_abort();
    test_latency();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/single_port_ram_bist.md
Name: single_port_ram_bist

Overview:
- Initiator and checker for the packed single-port RAM command interface.
- Drives the packed command word into a RAM top: bit 0 = write enable, bits [ADDR_W:1] = address, upper bits = payload. The full word is stored on a write.
- Runs a four-phase march (write pattern, read/check, write inverse, read/check) over every address, comparing read data against the expected words.
- Instantiated beside the RAM top in self-checking test designs; reports pass/fail, the first failing address and an error count.

Parameters:
- ADDR_W, 6, address width; the march covers 2**ADDR_W locations.
- DATA_W, 32, command/data word width; must be greater than ADDR_W+1.
- RD_LAT, 2, cycles from presenting a read command to valid rd_data (1 RAM address register + 1 top output register); legal range 1..4.
- SEED, 0, DATA_W-bit constant; its bits [DATA_W-1:ADDR_W+1] are XORed into the payload.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level/pulse; sampled only in IDLE or DONE.
- cmd_word  out  DATA_W  packed command to the RAM top.
- rd_data  in  DATA_W  read data returned by the RAM top.
- busy  out  1  high from the cycle after start is accepted until DONE is entered.
- done  out  1  high in DONE; held until the next start is accepted.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- fail_addr  out  ADDR_W  address of the first mismatch; 0 if no mismatch.
- err_count  out  8  mismatches counted; saturates at 255.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; cmd_word=0; busy, done and pass = 0; fail_addr=0; err_count=0; address counter 0; expected pipeline cleared.
- Payload definitions for address a:
  - P0(a) = SEED[DATA_W-1:ADDR_W+1] XOR zero-extended a.
  - P1(a) = bitwise NOT of P0(a).
- Write word for phase k: {Pk(a), a, 1'b1}. This word is also the expected read-back value.
- Read word: {0, a, 1'b0}.
- States:
  - IDLE: on start go to WR0 and clear err_count, fail_addr and pass.
  - WR0: one write per cycle, a = 0..2**ADDR_W-1 ascending. After the last address go to RD0.
  - RD0: one read per cycle, a ascending. The expected word is pushed into an RD_LAT-deep shift register with a valid bit. After the last issue, stay RD_LAT drain cycles issuing cmd_word=0, then go to WR1.
  - WR1: as WR0, using P1.
  - RD1: as RD0, using P1 expectations; after the drain go to DONE.
  - DONE: done=1, busy=0, cmd_word=0. On start, restart at WR0 with the same clears as IDLE.
- Compare rule: in a cycle where the shift-register output is valid, rd_data != expected counts as a mismatch.
  - err_count increments, saturating at 255.
  - fail_addr latches the address carried with that expectation, only if err_count was 0.
- Drain cycles issue cmd_word=0, i.e. we=0 (a read of address 0). Their expectations are not valid, so they are never compared.
- The address counter wraps to 0 at each phase boundary.
- Run length: 4*2**ADDR_W + 2*RD_LAT cycles from the first WR0 cycle to DONE.
- start while busy is ignored.
- Reset asserted mid-run aborts immediately to IDLE; RAM contents are not restored.
- pass = (err_count==0) while done=1; otherwise 0.

Decomposition:
- Package single_port_ram_bist_pkg:
  - state enum (IDLE, WR0, RD0, WR1, RD1, DONE);
  - function pack_cmd(payload, addr, we);
  - function payload(phase, addr, seed).
- Sub-module bist_expect_pipe: an RD_LAT-deep shift register of {valid, addr, expected word}, with a shift input and a tail output. It is reused by every read phase.

Test Plan:
- Reset then start, SEED=0, ideal RAM model with RD_LAT=2 -> WR0 addr 5 drives 0x0000028B; WR1 addr 5 drives 0xFFFFFD0B; done rises 260 cycles after the first WR0 cycle; pass=1; err_count=0.
- Stuck-at-0 on bit 10 at address 3 in the model -> phase 0 passes (expected 0x00000187, bit 10 already 0); RD1 at address 3 mismatches -> err_count=1, fail_addr=3, pass=0.
- Model returns 0 on every read -> 128 mismatches, err_count=128, fail_addr=0.
- start asserted during RD0, then reset pulsed for 1 cycle mid-WR1 -> start has no effect; on reset cmd_word=0 and busy=0 immediately (asynchronous); the next start runs a clean pass.
- RD_LAT=1 with a 1-cycle model, then RD_LAT=4 with a 4-cycle model -> both pass; run lengths 258 and 264 cycles.
- Back-to-back start in DONE -> done drops the next cycle, err_count clears, and a second run completes identically.
